// File: rtl/noc_link_pkg.sv
// Shared types for the NoC credit-based link: flit layout and packet framing states.
package noc_link_pkg;

    localparam int FLIT_WIDTH = 128;
    localparam int DEST_WIDTH = 6;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  is_tail;
    } flit_t;

    localparam int FLIT_BITS = $bits(flit_t);

    typedef enum logic {
        IDLE,
        IN_PKT
    } frame_state_t;

    function automatic flit_t pack_flit(
        input logic [FLIT_WIDTH-1:0] data,
        input logic [DEST_WIDTH-1:0] dest,
        input logic                  is_tail
    );
        flit_t f;
        f.data    = data;
        f.dest    = dest;
        f.is_tail = is_tail;
        return f;
    endfunction

endpackage

// File: rtl/noc_credit_tx_port_if.sv
// Upstream valid/ready flit stream plus the router-facing send/credit link.
interface noc_credit_tx_port_if;
    import noc_link_pkg::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [FLIT_WIDTH-1:0] in_data;
    logic [DEST_WIDTH-1:0] in_dest;
    logic                  in_is_tail;

    logic [FLIT_WIDTH-1:0] data_out;
    logic [DEST_WIDTH-1:0] dest_out;
    logic                  is_tail_out;
    logic                  send_out;
    logic                  credit_in;

    // The tx port itself
    modport master (
        input  in_valid,
        input  in_data,
        input  in_dest,
        input  in_is_tail,
        input  credit_in,
        output in_ready,
        output data_out,
        output dest_out,
        output is_tail_out,
        output send_out
    );

    // The surrounding source and router
    modport slave (
        output in_valid,
        output in_data,
        output in_dest,
        output in_is_tail,
        output credit_in,
        input  in_ready,
        input  data_out,
        input  dest_out,
        input  is_tail_out,
        input  send_out
    );

endinterface

// File: rtl/noc_skid_buffer.sv
// Two-entry skid buffer with a registered ready, so upstream never sees a combinational path.
module noc_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    output logic             pop_valid,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data
);

    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic [1:0]       count_next;
    logic             ready_reg;
    logic             push_fire;
    logic             pop_fire;
    logic [WIDTH-1:0] entries [2];

    assign push_fire = push_valid & ready_reg;
    assign pop_fire  = pop & (count_reg != 2'd0);

    always_comb begin
        count_next = count_reg;
        unique case ({push_fire, pop_fire})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Storage slots carry no reset; occupancy is tracked by count_reg alone.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic [WIDTH-1:0] entry_reg;

            always_ff @(posedge clk) begin
                if (push_fire && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            ready_reg  <= 1'b0;
        end else begin
            if (push_fire) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop_fire) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_next;
            // Ready reflects occupancy after this edge, so a full buffer blocks the next beat.
            ready_reg <= (count_next < 2'd2);
        end
    end

    assign push_ready = ready_reg;
    assign pop_valid  = (count_reg != 2'd0);
    assign pop_data   = entries[rd_ptr_reg];

endmodule

// File: rtl/noc_credit_tx_port.sv
// Credit-based NoC injection port: skid-buffers an upstream flit stream and sends only against credits.
module noc_credit_tx_port
    import noc_link_pkg::*;
#(
    parameter  int FLIT_BUFFER_DEPTH = 4,
    localparam int CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                    clk_noc,
    input  logic                    rst_noc_sync,
    noc_credit_tx_port_if.master    link,
    output logic [CREDIT_WIDTH-1:0] credits_avail,
    output logic                    err_credit_ovf,
    output logic                    err_dest_change
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

    flit_t                   in_flit;
    flit_t                   head_flit;
    logic [FLIT_BITS-1:0]    head_bits;
    logic                    head_valid;
    logic                    in_ready;
    logic                    accept;
    logic                    send;

    logic [CREDIT_WIDTH-1:0] cnt_reg;
    logic [CREDIT_WIDTH-1:0] cnt_next;
    logic                    ovf_set;
    logic                    err_credit_ovf_reg;

    frame_state_t            state_reg;
    logic [DEST_WIDTH-1:0]   pkt_dest_reg;
    logic                    err_dest_change_reg;

    logic [FLIT_WIDTH-1:0]   data_out_reg;
    logic [DEST_WIDTH-1:0]   dest_out_reg;
    logic                    is_tail_out_reg;
    logic                    send_out_reg;

    assign in_flit = pack_flit(link.in_data, link.in_dest, link.in_is_tail);

    noc_skid_buffer #(
        .WIDTH (FLIT_BITS)
    ) u_skid (
        .clk        (clk_noc),
        .srst       (rst_noc_sync),
        .push_valid (link.in_valid),
        .push_ready (in_ready),
        .push_data  (in_flit),
        .pop_valid  (head_valid),
        .pop        (send),
        .pop_data   (head_bits)
    );

    assign head_flit = flit_t'(head_bits);
    assign accept    = link.in_valid & in_ready;

    // Send decision uses only the registered count: a credit arriving now is spendable next edge.
    assign send = head_valid & (cnt_reg != '0);

    always_comb begin
        cnt_next = cnt_reg;
        ovf_set  = 1'b0;
        unique case ({send, link.credit_in})
            2'b10: cnt_next = cnt_reg - CREDIT_ONE;
            2'b01: begin
                if (cnt_reg == CREDIT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CREDIT_ONE;
                end
            end
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            cnt_reg            <= CREDIT_MAX;
            err_credit_ovf_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            if (ovf_set) begin
                err_credit_ovf_reg <= 1'b1;
            end
        end
    end

    // Output registers hold the last flit sent; only send_out marks a new one.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            data_out_reg    <= '0;
            dest_out_reg    <= '0;
            is_tail_out_reg <= 1'b0;
            send_out_reg    <= 1'b0;
        end else begin
            send_out_reg <= send;
            if (send) begin
                data_out_reg    <= head_flit.data;
                dest_out_reg    <= head_flit.dest;
                is_tail_out_reg <= head_flit.is_tail;
            end
        end
    end

    // Framing monitor: observes accepted flits only and never alters the data path.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_reg           <= IDLE;
            pkt_dest_reg        <= '0;
            err_dest_change_reg <= 1'b0;
        end else if (accept) begin
            unique case (state_reg)
                IDLE: begin
                    if (!link.in_is_tail) begin
                        state_reg    <= IN_PKT;
                        pkt_dest_reg <= link.in_dest;
                    end
                end
                IN_PKT: begin
                    if (link.in_dest != pkt_dest_reg) begin
                        err_dest_change_reg <= 1'b1;
                    end
                    if (link.in_is_tail) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign link.in_ready    = in_ready;
    assign link.data_out    = data_out_reg;
    assign link.dest_out    = dest_out_reg;
    assign link.is_tail_out = is_tail_out_reg;
    assign link.send_out    = send_out_reg;

    assign credits_avail    = cnt_reg;
    assign err_credit_ovf   = err_credit_ovf_reg;
    assign err_dest_change  = err_dest_change_reg;

endmodule

// File: tb/tb_noc_credit_tx_port.sv
// Directed bench for noc_credit_tx_port: cycle-exact credit/handshake checks plus an in-order flit scoreboard.
module tb_noc_credit_tx_port;
    import noc_link_pkg::*;

    logic       clk_noc = 1'b0;
    logic       rst_noc_sync = 1'b1;
    logic [2:0] credits_avail;
    logic       err_credit_ovf;
    logic       err_dest_change;

    int n_checks = 0;
    int n_pass   = 0;

    flit_t exp_q [$];
    flit_t mon_f;

    int exp_send [6] = '{0, 1, 1, 1, 1, 0};
    int exp_cred [6] = '{4, 3, 2, 1, 0, 0};
    int exp_rdy  [6] = '{1, 1, 1, 1, 1, 0};

    always #5 clk_noc = ~clk_noc;

    noc_credit_tx_port_if bus ();

    noc_credit_tx_port #(
        .FLIT_BUFFER_DEPTH (4)
    ) dut (
        .clk_noc         (clk_noc),
        .rst_noc_sync    (rst_noc_sync),
        .link            (bus.master),
        .credits_avail   (credits_avail),
        .err_credit_ovf  (err_credit_ovf),
        .err_dest_change (err_dest_change)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk_noc);
        #1;
    endtask

    // Present one flit for one edge; it is expected downstream only if in_ready was high at that edge.
    task automatic cycle_flit(input logic [127:0] d, input logic [5:0] ds, input logic t);
        logic acc;
        bus.in_valid   = 1'b1;
        bus.in_data    = d;
        bus.in_dest    = ds;
        bus.in_is_tail = t;
        acc = bus.in_ready;
        tick();
        if (acc) begin
            exp_q.push_back(pack_flit(d, ds, t));
        end
    endtask

    always begin
        @(posedge clk_noc);
        #1;
        if (bus.send_out === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_send", 128'(1), 128'(0));
            end else begin
                mon_f = exp_q.pop_front();
                $display("send data=%0h dest=%0h tail=%b", bus.data_out, bus.dest_out, bus.is_tail_out);
                chk("out_data", 128'(bus.data_out), 128'(mon_f.data));
                chk("out_dest", 128'(bus.dest_out), 128'(mon_f.dest));
                chk("out_tail", 128'(bus.is_tail_out), 128'(mon_f.is_tail));
            end
        end
    end

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.in_dest    = '0;
        bus.in_is_tail = 1'b0;
        bus.credit_in  = 1'b0;

        // Test 1: reset state, then six single-flit packets with no credits returned
        rst_noc_sync = 1'b1;
        tick();
        tick();
        chk("rst_ready", 128'(bus.in_ready), 128'(0));
        chk("rst_send", 128'(bus.send_out), 128'(0));
        chk("rst_data", 128'(bus.data_out), 128'(0));
        chk("rst_dest", 128'(bus.dest_out), 128'(0));
        chk("rst_tail", 128'(bus.is_tail_out), 128'(0));
        chk("rst_credits", 128'(credits_avail), 128'(4));
        chk("rst_ovf", 128'(err_credit_ovf), 128'(0));
        chk("rst_dest_err", 128'(err_dest_change), 128'(0));
        rst_noc_sync = 1'b0;
        tick();
        chk("ready_after_rst", 128'(bus.in_ready), 128'(1));

        for (int i = 0; i < 6; i++) begin
            cycle_flit(128'h1000 + 128'(i), 6'(i), 1'b1);
            chk("t1_send", 128'(bus.send_out), 128'(exp_send[i]));
            chk("t1_credits", 128'(credits_avail), 128'(exp_cred[i]));
            chk("t1_ready", 128'(bus.in_ready), 128'(exp_rdy[i]));
        end
        bus.in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("t1_stall_send", 128'(bus.send_out), 128'(0));
            chk("t1_stall_credits", 128'(credits_avail), 128'(0));
            chk("t1_stall_ready", 128'(bus.in_ready), 128'(0));
        end

        // Test 2: a single credit releases exactly one flit one cycle later
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        chk("t2_send0", 128'(bus.send_out), 128'(0));
        chk("t2_credits1", 128'(credits_avail), 128'(1));
        tick();
        chk("t2_send1", 128'(bus.send_out), 128'(1));
        chk("t2_credits0", 128'(credits_avail), 128'(0));
        tick();
        chk("t2_send_after", 128'(bus.send_out), 128'(0));
        chk("t2_credits_after", 128'(credits_avail), 128'(0));

        // Test 3: with two credits, continuous credit return sustains one flit per cycle
        rst_noc_sync = 1'b1;
        tick();
        exp_q.delete();
        rst_noc_sync = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            cycle_flit(128'h2000 + 128'(i), 6'h11, 1'b1);
        end
        chk("t3_credits_start", 128'(credits_avail), 128'(2));
        bus.credit_in = 1'b1;
        for (int i = 3; i < 13; i++) begin
            cycle_flit(128'h2000 + 128'(i), 6'h11, 1'b1);
            chk("t3_send", 128'(bus.send_out), 128'(1));
            chk("t3_credits", 128'(credits_avail), 128'(2));
        end
        bus.in_valid  = 1'b0;
        bus.credit_in = 1'b0;
        tick();
        chk("t3_drain_send", 128'(bus.send_out), 128'(1));
        chk("t3_drain_credits", 128'(credits_avail), 128'(1));
        bus.credit_in = 1'b1;
        repeat (3) tick();
        bus.credit_in = 1'b0;
        tick();
        chk("t3_full_credits", 128'(credits_avail), 128'(4));
        chk("t3_ovf_clear", 128'(err_credit_ovf), 128'(0));

        // Test 4: extra credit while full saturates and sets the sticky overflow flag
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        chk("t4_credits_sat", 128'(credits_avail), 128'(4));
        chk("t4_ovf_set", 128'(err_credit_ovf), 128'(1));
        repeat (3) tick();
        chk("t4_ovf_sticky", 128'(err_credit_ovf), 128'(1));
        chk("t4_credits_hold", 128'(credits_avail), 128'(4));

        // Test 5: destination change inside a packet is flagged, flits pass unchanged
        cycle_flit(128'hAAA, 6'h05, 1'b0);
        cycle_flit(128'hBBB, 6'h05, 1'b0);
        chk("t5_no_err_yet", 128'(err_dest_change), 128'(0));
        cycle_flit(128'hCCC, 6'h09, 1'b1);
        chk("t5_dest_err", 128'(err_dest_change), 128'(1));
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("t5_drained", 128'(exp_q.size()), 128'(0));
        chk("t5_credits", 128'(credits_avail), 128'(1));
        chk("t5_ovf_still", 128'(err_credit_ovf), 128'(1));

        // Test 6: reset with two flits buffered and one credit drops everything
        cycle_flit(128'h3000, 6'h01, 1'b1);
        cycle_flit(128'h3001, 6'h01, 1'b1);
        cycle_flit(128'h3002, 6'h01, 1'b1);
        chk("t6_full_ready", 128'(bus.in_ready), 128'(0));
        chk("t6_credits0", 128'(credits_avail), 128'(0));
        bus.in_valid  = 1'b0;
        bus.credit_in = 1'b1;
        tick();
        bus.credit_in = 1'b0;
        chk("t6_credits1", 128'(credits_avail), 128'(1));
        rst_noc_sync = 1'b1;
        tick();
        chk("t6_rst_send", 128'(bus.send_out), 128'(0));
        chk("t6_rst_ready", 128'(bus.in_ready), 128'(0));
        chk("t6_rst_credits", 128'(credits_avail), 128'(4));
        chk("t6_rst_ovf", 128'(err_credit_ovf), 128'(0));
        chk("t6_rst_dest_err", 128'(err_dest_change), 128'(0));
        exp_q.delete();
        rst_noc_sync = 1'b0;
        tick();
        chk("t6_ready_after", 128'(bus.in_ready), 128'(1));
        chk("t6_send_after", 128'(bus.send_out), 128'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t6_no_send", 128'(bus.send_out), 128'(0));
            chk("t6_credits_hold", 128'(credits_avail), 128'(4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
